uart_rx_core: RTL and testbench

// - Parametrised UART receiver: serial rx line -> DATA_BITS-wide word with valid/ready output handshake.
// - Mid-bit sampling from a clock/baud ratio counter; LSB first; false-start rejection; framing/overrun reporting.
// - Sits between the board rx pin and the byte-consumer logic; replaces the fixed-ratio, timer-driven receiver.

---
 rtl/uart_rx_core.sv | 133 +++++++++++++
 tb/tb_uart_rx_core.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// UART receiver: mid-bit sampled, LSB first, valid/ready output.
// Define UART_RX_PARITY_EN to add a checked parity bit per frame.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 400,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0] LBIT  = 4'(DATA_BITS - 1);
  localparam logic [3:0] LSTOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK, DELIVER
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] idx, idx_n;
  logic [DATA_BITS-1:0] shreg;
  logic rx_m, rx_s;
  logic tick, par_bad;
  logic fe_n, pe_n, ov_n, load, accept;

  assign tick   = (cnt == LAST);
  assign busy   = (state != IDLE);
  assign accept = rx_valid & rx_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (!rx_s) state_n = START;
      START:   if (cnt == MID) state_n = rx_s ? IDLE : DATA;
      DATA:
        if (tick && idx == LBIT) begin
`ifdef UART_RX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      PARITY:  if (tick) state_n = STOP;
      STOP:
        if (tick) begin
          if (!rx_s) state_n = BRK;
          else if (idx == LSTOP) state_n = DELIVER;
        end
      BRK:     if (rx_s) state_n = IDLE;
      DELIVER: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cnt_n = cnt + CW'(1);
    idx_n = idx;
    if (state_n != state || state == IDLE || tick)
      cnt_n = '0;
    if (state_n != state)
      idx_n = '0;
    else if ((state == DATA || state == STOP) && tick)
      idx_n = idx + 4'd1;
  end

  // Delivery decision; a held, unaccepted word is never overwritten.
  always_comb begin
    fe_n = (state == STOP) && tick && !rx_s;
    pe_n = (state == DELIVER) && par_bad;
    load = (state == DELIVER) && !par_bad && (!rx_valid || accept);
    ov_n = (state == DELIVER) && !par_bad && rx_valid && !rx_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      frame_err  <= fe_n;
      parity_err <= pe_n;
      overrun    <= ov_n;
      if (state == DATA && tick)
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (load) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      par_bad <= 1'b0;
    else if (state == START)
      par_bad <= 1'b0;
    else if (state == PARITY && tick)
      par_bad <= ^shreg ^ rx_s ^ PARITY_ODD[0];
  end
`else
  assign par_bad = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frame table plus corner sequences.
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_core;

  localparam int CPB  = 16;
  localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  logic       clk, rst, rx, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err;
  logic       overrun, busy;

  uart_rx_core #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(8),
    .STOP_BITS(1),
    .PARITY_ODD(PODD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .overrun(overrun),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_val = 0, n_fe = 0, n_pe = 0, n_ov = 0;
  int rise_cyc = 0, fall_cyc = 0;
  logic vq = 1'b0;
  int checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    vq <= rx_valid;
    if (rx_valid && !vq) begin
      n_val    <= n_val + 1;
      rise_cyc <= cyc;
    end
    if (frame_err)  n_fe <= n_fe + 1;
    if (parity_err) n_pe <= n_pe + 1;
    if (overrun)    n_ov <= n_ov + 1;
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic settle(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_bit(logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Leaves rx at the stop level; caller decides what follows.
  task automatic send_frame(logic [7:0] d, logic badpar, logic stop);
    @(negedge clk);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d ^ PODD[0] ^ badpar);
`else
    if (badpar) $display("note: parity bit not sent");
`endif
    send_bit(stop);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         ev;
    int         efe;
  } vec_t;

  vec_t tbl[6];
  int s_val, s_fe, s_pe, s_ov;

  task automatic snap();
    s_val = n_val;
    s_fe  = n_fe;
    s_pe  = n_pe;
    s_ov  = n_ov;
  endtask

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1, 0};
    tbl[1] = '{8'h3C, 1'b1, 1, 0};
    tbl[2] = '{8'h00, 1'b1, 1, 0};
    tbl[3] = '{8'hFF, 1'b1, 1, 0};
    tbl[4] = '{8'h55, 1'b0, 0, 1};
    tbl[5] = '{8'h81, 1'b1, 1, 0};

    rst = 1'b0; rx = 1'b1; rx_ready = 1'b0;
    #1;
    chk("reset_valid", rx_valid, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_flags", {frame_err, parity_err, overrun}, 0);
    chk("reset_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rx_ready = 1'b1;
    settle(4);

    for (int i = 0; i < 6; i++) begin
      snap();
      send_frame(tbl[i].d, 1'b0, tbl[i].stop);
      rx = 1'b1;
      settle(30);
      chk("tbl_valid", n_val - s_val, tbl[i].ev);
      chk("tbl_fe", n_fe - s_fe, tbl[i].efe);
      chk("tbl_pe_ov", (n_pe - s_pe) + (n_ov - s_ov), 0);
      chk("tbl_busy", busy, 0);
      if (tbl[i].ev != 0) begin
        chk("tbl_data", rx_data, tbl[i].d);
        chk("tbl_latency", rise_cyc - fall_cyc - 1, LAT);
        chk("tbl_vdrop", rx_valid, 0);
      end
    end

    // start-bit glitch
    snap();
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("glitch_busy_on", busy, 1);
    rx = 1'b1;
    settle(20);
    chk("glitch_busy_off", busy, 0);
    chk("glitch_valid", n_val - s_val, 0);
    chk("glitch_fe", n_fe - s_fe, 0);
    send_frame(8'h3C, 1'b0, 1'b1);
    rx = 1'b1;
    settle(30);
    chk("glitch_next_data", rx_data, 8'h3C);
    chk("glitch_next_valid", n_val - s_val, 1);

    // overrun with consumer stalled
    rx_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b0, 1'b1);
    rx = 1'b1;
    send_frame(8'h22, 1'b0, 1'b1);
    rx = 1'b1;
    settle(30);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_count", n_ov - s_ov, 1);
    chk("ovr_rises", n_val - s_val, 1);
    @(negedge clk);
    rx_ready = 1'b1;
    settle(2);
    chk("ovr_accept", rx_valid, 0);
    chk("ovr_count_after", n_ov - s_ov, 1);

    // framing error followed by a long break
    snap();
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    #1;
    chk("brk_fe", n_fe - s_fe, 1);
    chk("brk_busy", busy, 1);
    rx = 1'b1;
    settle(20);
    chk("brk_fe_after", n_fe - s_fe, 1);
    chk("brk_idle", busy, 0);
    chk("brk_valid", n_val - s_val, 0);

`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    rx = 1'b1;
    settle(30);
    chk("par_bad_pe", n_pe - s_pe, 1);
    chk("par_bad_valid", n_val - s_val, 0);
    send_frame(8'h07, 1'b0, 1'b1);
    rx = 1'b1;
    settle(30);
    chk("par_ok_data", rx_data, 8'h07);
    chk("par_ok_valid", n_val - s_val, 1);
    chk("par_ok_pe", n_pe - s_pe, 1);
`endif

    // reset in the middle of a data bit
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1);
    rx = 1'b1;
    settle(30);
    chk("pre_rst_valid", rx_valid, 1);
    snap();
    @(negedge clk);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    rx_ready = 1'b1;
    settle(40);
    chk("rst_flags", (n_fe - s_fe) + (n_pe - s_pe) + (n_ov - s_ov), 0);
    send_frame(8'h81, 1'b0, 1'b1);
    rx = 1'b1;
    settle(30);
    chk("rst_next_data", rx_data, 8'h81);
    chk("rst_next_valid", n_val - s_val, 1);
    chk("rst_next_lat", rise_cyc - fall_cyc - 1, LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
